// File: rtl/wb_streamer_pkg.sv
// Shared Wishbone burst encodings and FSM state codes for the stream writer.
package wb_streamer_pkg;

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INC_BURST = 3'b010;
    localparam logic [2:0] CTI_END_BURST = 3'b111;

    localparam logic [1:0] BTE_LINEAR    = 2'b00;

    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_WAIT_SPACE = 2'b01;
    localparam logic [1:0] ST_BURST      = 2'b10;

    function automatic logic [2:0] beat_cti(input logic last_beat);
        return last_beat ? CTI_END_BURST : CTI_INC_BURST;
    endfunction

endpackage

// File: rtl/wb_stream_writer_fifo.sv
// Synchronous first-word-fall-through FIFO with a free-slot count for burst admission.
module wb_stream_writer_fifo #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_empty,
    output logic [AW:0]   o_free
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_rd      = i_rd_en && (r_count != '0);
    // A read in the same cycle frees the slot, so a write at full is still safe.
    assign w_wr      = i_wr_en && (!w_full || w_rd);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_free    = CW'(DEPTH) - r_count;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_writer.sv
// Reads a memory buffer with Wishbone incrementing bursts and replays it on a stream port.
module wb_stream_writer
    import wb_streamer_pkg::*;
#(
    parameter int unsigned WB_AW         = 32,
    parameter int unsigned WB_DW         = 32,
    parameter int unsigned FIFO_AW       = 5,
    parameter int unsigned MAX_BURST_LEN = 128
) (
    input  logic               clk,
    input  logic               rst,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    output logic [WB_DW-1:0]   stream_m_data_o,
    output logic               stream_m_valid_o,
    input  logic               stream_m_ready_i,
    input  logic               cfg_enable_i,
    input  logic [WB_AW-1:0]   cfg_start_adr_i,
    input  logic [WB_AW-1:0]   cfg_buf_size_i,
    input  logic [WB_AW-1:0]   cfg_burst_size_i,
    output logic               busy_o,
    output logic               irq_o,
    output logic               err_o
);

    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AW;
    // A burst longer than the FIFO could never find space, so the FIFO depth also caps it.
    localparam int unsigned BURST_CAP  = (MAX_BURST_LEN < FIFO_DEPTH) ? MAX_BURST_LEN : FIFO_DEPTH;

    logic [1:0]       r_state;
    logic [WB_AW-1:0] r_adr;
    logic [WB_AW-1:0] r_words_left;
    logic [WB_AW-1:0] r_beats_left;
    logic [WB_AW-1:0] r_burst_size;
    logic             r_cyc;
    logic [2:0]       r_cti;
    logic             r_busy;
    logic             r_irq;
    logic             r_err;
    logic             r_enable_d;

    logic [1:0]       w_state_nxt;
    logic [WB_AW-1:0] w_adr_nxt;
    logic [WB_AW-1:0] w_words_left_nxt;
    logic [WB_AW-1:0] w_beats_left_nxt;
    logic [WB_AW-1:0] w_burst_size_nxt;
    logic             w_cyc_nxt;
    logic [2:0]       w_cti_nxt;
    logic             w_busy_nxt;
    logic             w_irq_nxt;
    logic             w_err_nxt;

    logic             w_en_rise;
    logic             w_ack;
    logic             w_fifo_wr;
    logic             w_fifo_rd;
    logic             w_fifo_empty;
    logic [FIFO_AW:0] w_fifo_free;
    logic [WB_AW-1:0] w_bsz_eff;
    logic [WB_AW-1:0] w_burst_len;
    logic             w_space_ok;

    assign w_en_rise = cfg_enable_i && !r_enable_d;
    // A response carrying both ack and rty is treated as a retry.
    assign w_ack     = wbm_ack_i && !wbm_rty_i;
    assign w_fifo_wr = (r_state == ST_BURST) && w_ack && !wbm_err_i;
    assign w_fifo_rd = stream_m_ready_i && !w_fifo_empty;

    always_comb begin
        w_bsz_eff   = (r_burst_size == '0) ? WB_AW'(1) : r_burst_size;
        w_burst_len = (w_bsz_eff < WB_AW'(BURST_CAP)) ? w_bsz_eff : WB_AW'(BURST_CAP);
        if (r_words_left < w_burst_len) begin
            w_burst_len = r_words_left;
        end
    end

    assign w_space_ok = (WB_AW'(w_fifo_free) >= w_burst_len);

    always_comb begin
        w_state_nxt      = r_state;
        w_adr_nxt        = r_adr;
        w_words_left_nxt = r_words_left;
        w_beats_left_nxt = r_beats_left;
        w_burst_size_nxt = r_burst_size;
        w_cyc_nxt        = r_cyc;
        w_cti_nxt        = r_cti;
        w_busy_nxt       = r_busy;
        w_irq_nxt        = 1'b0;
        w_err_nxt        = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_en_rise && (cfg_buf_size_i != '0)) begin
                    w_state_nxt      = ST_WAIT_SPACE;
                    w_adr_nxt        = cfg_start_adr_i;
                    w_words_left_nxt = cfg_buf_size_i;
                    w_burst_size_nxt = cfg_burst_size_i;
                    w_busy_nxt       = 1'b1;
                    w_err_nxt        = 1'b0;
                end
            end
            ST_WAIT_SPACE: begin
                if (w_space_ok) begin
                    w_state_nxt      = ST_BURST;
                    w_cyc_nxt        = 1'b1;
                    w_beats_left_nxt = w_burst_len;
                    w_cti_nxt        = beat_cti(w_burst_len == WB_AW'(1));
                end
            end
            ST_BURST: begin
                if (wbm_err_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cyc_nxt   = 1'b0;
                    w_cti_nxt   = CTI_CLASSIC;
                    w_busy_nxt  = 1'b0;
                    w_irq_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                end else if (w_ack) begin
                    w_adr_nxt        = r_adr + WB_AW'(4);
                    w_words_left_nxt = r_words_left - WB_AW'(1);
                    w_beats_left_nxt = r_beats_left - WB_AW'(1);
                    if (r_beats_left == WB_AW'(1)) begin
                        w_cyc_nxt = 1'b0;
                        w_cti_nxt = CTI_CLASSIC;
                        if (r_words_left == WB_AW'(1)) begin
                            w_state_nxt = ST_IDLE;
                            w_busy_nxt  = 1'b0;
                            w_irq_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_WAIT_SPACE;
                        end
                    end else begin
                        w_cti_nxt = beat_cti(r_beats_left == WB_AW'(2));
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = 1'b0;
                w_cti_nxt   = CTI_CLASSIC;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_adr        <= '0;
            r_words_left <= '0;
            r_beats_left <= '0;
            r_burst_size <= '0;
            r_cyc        <= 1'b0;
            r_cti        <= CTI_CLASSIC;
            r_busy       <= 1'b0;
            r_irq        <= 1'b0;
            r_err        <= 1'b0;
            r_enable_d   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_adr        <= w_adr_nxt;
            r_words_left <= w_words_left_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_burst_size <= w_burst_size_nxt;
            r_cyc        <= w_cyc_nxt;
            r_cti        <= w_cti_nxt;
            r_busy       <= w_busy_nxt;
            r_irq        <= w_irq_nxt;
            r_err        <= w_err_nxt;
            r_enable_d   <= cfg_enable_i;
        end
    end

    wb_stream_writer_fifo #(
        .DW (WB_DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (wbm_dat_i),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (stream_m_data_o),
        .o_empty   (w_fifo_empty),
        .o_free    (w_fifo_free)
    );

    assign wbm_adr_o        = r_adr;
    assign wbm_dat_o        = '0;
    assign wbm_sel_o        = '1;
    assign wbm_we_o         = 1'b0;
    assign wbm_cyc_o        = r_cyc;
    assign wbm_stb_o        = r_cyc;
    assign wbm_cti_o        = r_cti;
    assign wbm_bte_o        = BTE_LINEAR;
    assign stream_m_valid_o = !w_fifo_empty;
    assign busy_o           = r_busy;
    assign irq_o            = r_irq;
    assign err_o            = r_err;

endmodule
